// File: rtl/alu_system_controller.sv
// Hardwired fetch/decode/execute sequencer for the ALU datapath system.
// Two fetch phases load the IR, one or two execute phases follow.
module alu_system_controller (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IROut,
   input  logic [3:0]  ALU_Flags,
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [2:0]  RF_FunSel,
   output logic [3:0]  RF_RegSel,
   output logic [3:0]  RF_ScrSel,
   output logic [4:0]  ALU_FunSel,
   output logic        ALU_WF,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [2:0]  ARF_FunSel,
   output logic [2:0]  ARF_RegSel,
   output logic        IR_LH,
   output logic        IR_Write,
   output logic        Mem_CS,
   output logic        Mem_WR,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic        Halted
);

   typedef enum logic [2:0] {
      S_T0   = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_HALT = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [3:0] opcode;
   logic [1:0] rd, rs1, rs2;
   logic       z;
   logic [3:0] rd_oh;
   logic       is_br, is_ldi, is_mem, is_alu, is_hlt;
   logic       unused_bits;

   assign opcode      = IROut[15:12];
   assign rd          = IROut[11:10];
   assign rs1         = IROut[9:8];
   assign rs2         = IROut[7:6];
   assign z           = ALU_Flags[3];
   assign rd_oh       = 4'b1000 >> rd;
   assign unused_bits = ^{ALU_Flags[2:0], IROut[5:0]};

   // BNE falls through to the idle word when Z is set
   assign is_br  = (opcode == 4'h1) || (opcode == 4'h2 && !z);
   assign is_ldi = (opcode == 4'h3);
   assign is_mem = (opcode == 4'h4) || (opcode == 4'h5);
   assign is_alu = (opcode >= 4'h6) && (opcode <= 4'h9);
   assign is_hlt = (opcode == 4'hF);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= S_T0;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      RF_OutASel  = 3'b000;
      RF_OutBSel  = 3'b000;
      RF_FunSel   = 3'b000;
      RF_RegSel   = 4'b0000;
      RF_ScrSel   = 4'b0000;
      ALU_FunSel  = 5'b00000;
      ALU_WF      = 1'b0;
      ARF_OutCSel = 2'b00;
      ARF_OutDSel = 2'b00;
      ARF_FunSel  = 3'b000;
      ARF_RegSel  = 3'b000;
      IR_LH       = 1'b0;
      IR_Write    = 1'b0;
      Mem_CS      = 1'b1;
      Mem_WR      = 1'b0;
      MuxASel     = 2'b00;
      MuxBSel     = 2'b00;
      MuxCSel     = 1'b0;
      Halted      = 1'b0;
      if (Reset) begin
         // hold PC cleared while reset is high
         state_nx   = S_T0;
         ARF_RegSel = 3'b100;
         ARF_FunSel = 3'b011;
      end else begin
         unique case (state)
            S_T0, S_T1: begin
               state_nx   = (state == S_T0) ? S_T1 : S_T2;
               Mem_CS     = 1'b0;
               IR_Write   = 1'b1;
               IR_LH      = (state == S_T1);
               ARF_RegSel = 3'b100;
               ARF_FunSel = 3'b001;
            end
            S_T2: begin
               state_nx = S_T0;
               unique case (1'b1)
                  is_br: begin
                     MuxBSel    = 2'b11;
                     ARF_RegSel = 3'b100;
                     ARF_FunSel = 3'b010;
                  end
                  is_ldi: begin
                     MuxASel   = 2'b11;
                     RF_FunSel = 3'b010;
                     RF_RegSel = rd_oh;
                  end
                  is_mem: begin
                     state_nx   = S_T3;
                     MuxBSel    = 2'b11;
                     ARF_RegSel = 3'b010;
                     ARF_FunSel = 3'b010;
                  end
                  is_alu: begin
                     RF_OutASel = {1'b0, rs1};
                     RF_OutBSel = {1'b0, rs2};
                     ALU_WF     = 1'b1;
                     MuxASel    = 2'b00;
                     RF_FunSel  = 3'b010;
                     RF_RegSel  = rd_oh;
                     unique case (opcode)
                        4'h6:    ALU_FunSel = 5'b10100;
                        4'h7:    ALU_FunSel = 5'b10110;
                        4'h8:    ALU_FunSel = 5'b10111;
                        default: ALU_FunSel = 5'b11000;
                     endcase
                  end
                  is_hlt:  state_nx = S_HALT;
                  default: state_nx = S_T0;
               endcase
            end
            S_T3: begin
               state_nx    = S_T0;
               ARF_OutDSel = 2'b10;
               Mem_CS      = 1'b0;
               if (opcode == 4'h4) begin
                  MuxASel   = 2'b10;
                  RF_FunSel = 3'b010;
                  RF_RegSel = rd_oh;
               end else begin
                  RF_OutASel = {1'b0, rd};
                  ALU_FunSel = 5'b10000;
                  MuxCSel    = 1'b0;
                  Mem_WR     = 1'b1;
               end
            end
            S_HALT: begin
               state_nx = S_HALT;
               Halted   = 1'b1;
            end
            default: state_nx = S_T0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_system_controller.sv
// Bench for alu_system_controller: a behavioural datapath obeys the control
// words, and an instruction-level ISA model predicts architectural state.
module tb_alu_system_controller;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] IROut;
   logic [3:0]  ALU_Flags;
   logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
   logic [3:0]  RF_RegSel, RF_ScrSel;
   logic [4:0]  ALU_FunSel;
   logic        ALU_WF;
   logic [1:0]  ARF_OutCSel, ARF_OutDSel;
   logic [2:0]  ARF_FunSel, ARF_RegSel;
   logic        IR_LH, IR_Write, Mem_CS, Mem_WR;
   logic [1:0]  MuxASel, MuxBSel;
   logic        MuxCSel, Halted;

   alu_system_controller dut (
      .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALU_Flags(ALU_Flags),
      .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
      .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
      .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
      .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
      .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
      .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR),
      .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
      .Halted(Halted)
   );

   always #5 Clock = ~Clock;

   // behavioural datapath driven by the control word
   logic [7:0]  img [65536];
   logic [7:0]  mem [65536];
   logic [15:0] r [4];
   logic [15:0] pc, ar, ir;
   logic        z;
   logic        load = 1'b0;
   logic [15:0] a, b, alu_out, maddr, mux_a, mux_b;
   logic [7:0]  mout;

   assign IROut     = ir;
   assign ALU_Flags = {z, 3'b000};

   always_comb begin
      a     = r[RF_OutASel[1:0]];
      b     = r[RF_OutBSel[1:0]];
      maddr = (ARF_OutDSel == 2'b10) ? ar : pc;
      mout  = mem[maddr];
      case (ALU_FunSel)
         5'b10000: alu_out = a;
         5'b10100: alu_out = a + b;
         5'b10110: alu_out = a - b;
         5'b10111: alu_out = a & b;
         5'b11000: alu_out = a | b;
         default:  alu_out = 16'h0;
      endcase
      case (MuxASel)
         2'b00:   mux_a = alu_out;
         2'b10:   mux_a = {8'h0, mout};
         2'b11:   mux_a = {8'h0, ir[7:0]};
         default: mux_a = 16'h0;
      endcase
      case (MuxBSel)
         2'b00:   mux_b = alu_out;
         2'b10:   mux_b = {8'h0, mout};
         2'b11:   mux_b = {8'h0, ir[7:0]};
         default: mux_b = 16'h0;
      endcase
   end

   always @(posedge Clock) begin
      if (load) begin
         for (int i = 0; i < 65536; i++) mem[i] <= img[i];
         for (int i = 0; i < 4; i++) r[i] <= 16'h0;
         ar <= 16'h0;
         ir <= 16'h0;
         z  <= 1'b0;
      end else begin
         if (!Mem_CS && Mem_WR && !MuxCSel) mem[maddr] <= alu_out[7:0];
         if (IR_Write && !Mem_CS) begin
            if (IR_LH) ir[15:8] <= mout;
            else       ir[7:0]  <= mout;
         end
         if (RF_FunSel == 3'b010)
            for (int i = 0; i < 4; i++)
               if (RF_RegSel[3-i]) r[i] <= mux_a;
         if (ARF_RegSel[1] && ARF_FunSel == 3'b010) ar <= mux_b;
         if (ALU_WF) z <= (alu_out == 16'h0);
      end
      if (ARF_RegSel[2])
         case (ARF_FunSel)
            3'b001:  pc <= pc + 16'h1;
            3'b010:  pc <= mux_b;
            3'b011:  pc <= 16'h0;
            default: pc <= pc;
         endcase
   end

   // instruction-level reference model
   logic [7:0]  rmem [65536];
   logic [15:0] rr [4];
   logic [15:0] rpc;
   logic        rz, rhalt;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic put(input int adr, input logic [15:0] w);
      img[adr]   = w[7:0];
      img[adr+1] = w[15:8];
   endtask

   task automatic ref_step(output int cyc, output int alu,
                           output logic [3:0] op, output logic [7:0] imm);
      logic [15:0] w, x, y, res;
      logic [1:0]  rd;
      w   = {rmem[rpc + 16'h1], rmem[rpc]};
      rpc = rpc + 16'h2;
      op  = w[15:12];
      rd  = w[11:10];
      imm = w[7:0];
      x   = rr[w[9:8]];
      y   = rr[w[7:6]];
      cyc = (op == 4'h4 || op == 4'h5) ? 4 : 3;
      alu = (op >= 4'h6 && op <= 4'h9) ? 1 : 0;
      case (op)
         4'h1: rpc = {8'h0, imm};
         4'h2: if (!rz) rpc = {8'h0, imm};
         4'h3: rr[rd] = {8'h0, imm};
         4'h4: rr[rd] = {8'h0, rmem[{8'h0, imm}]};
         4'h5: rmem[{8'h0, imm}] = rr[rd][7:0];
         4'hF: rhalt = 1'b1;
         default: ;
      endcase
      if (alu == 1) begin
         case (op)
            4'h6:    res = x + y;
            4'h7:    res = x - y;
            4'h8:    res = x & y;
            default: res = x | y;
         endcase
         rr[rd] = res;
         rz     = (res == 16'h0);
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < 65536; i++) rmem[i] = img[i];
      for (int i = 0; i < 4; i++) rr[i] = 16'h0;
      rpc   = 16'h0;
      rz    = 1'b0;
      rhalt = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      load  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge Clock);
         #1;
         load = 1'b0;
         chk("rst_pc", pc, 16'h0);
         chk("rst_word",
             {ARF_RegSel, ARF_FunSel, Halted, Mem_CS, IR_Write, Mem_WR,
              ALU_WF, RF_RegSel},
             {3'b100, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});
      end
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic run(input int n);
      int cyc, alu, wf;
      logic [3:0] op;
      logic [7:0] imm;
      for (int i = 0; i < n && !rhalt; i++) begin
         ref_step(cyc, alu, op, imm);
         wf = 0;
         for (int k = 0; k < cyc; k++) begin
            wf += int'(ALU_WF);
            @(posedge Clock);
            #1;
         end
         chk("alu_wf", wf, alu);
         if (rhalt) chk("halted", Halted, 1'b1);
         else chk("at_t0", {Halted, IR_Write, IR_LH}, 3'b010);
         chk("pc", pc, rpc);
         chk("regs", {r[0], r[1], r[2], r[3]}, {rr[0], rr[1], rr[2], rr[3]});
         chk("zflag", z, rz);
         if (op == 4'h5) chk("mem", mem[{8'h0, imm}], rmem[{8'h0, imm}]);
      end
   endtask

   initial begin
      logic [3:0] op;
      for (int i = 0; i < 65536; i++) img[i] = 8'h0;
      put(16'h00, 16'h3005);
      put(16'h02, 16'h3007);
      put(16'h04, 16'h3407);
      put(16'h06, 16'h7840);
      put(16'h08, 16'h2020);
      put(16'h0A, 16'h6840);
      put(16'h0C, 16'h2020);
      put(16'h20, 16'h30AB);
      put(16'h22, 16'h5040);
      put(16'h24, 16'h4C40);
      put(16'h26, 16'hC5A3);
      put(16'h28, 16'hF000);
      do_reset();
      run(1);
      chk("ldi_r1", r[0], 16'h0005);
      chk("ldi_pc", pc, 16'h0002);
      run(20);
      chk("st_mem", mem[16'h40], 8'hAB);
      chk("ld_r4", r[3], 16'h00AB);
      for (int k = 0; k < 10; k++) begin
         @(posedge Clock);
         #1;
         chk("halt_hold", {Halted, pc}, {1'b1, 16'h002A});
      end

      // reset arriving in the T3 of a store must abort the write
      for (int i = 0; i < 65536; i++) img[i] = 8'h0;
      put(16'h00, 16'h3077);
      put(16'h02, 16'h5040);
      do_reset();
      run(1);
      for (int k = 0; k < 3; k++) begin
         @(posedge Clock);
         #1;
      end
      chk("st_t3", {Mem_CS, Mem_WR}, 2'b01);
      #2 Reset = 1'b1;
      #1 chk("rst_async", {Mem_WR, ARF_FunSel}, {1'b0, 3'b011});
      @(posedge Clock);
      #1;
      chk("st_abort", mem[16'h40], 8'h00);
      chk("st_abort_pc", pc, 16'h0);
      @(negedge Clock);
      Reset = 1'b0;
      #1 chk("rst_t0", {IR_Write, IR_LH, Mem_CS}, 3'b100);

      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < 65536; i++) img[i] = 8'h0;
         for (int i = 0; i < 512; i += 2) begin
            op = ($urandom_range(0, 31) == 0) ? 4'hF
                 : 4'($urandom_range(0, 14));
            put(i, {op, 12'($urandom)});
         end
         do_reset();
         run(40);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
